// File: rtl/psx_io_pkg.sv
// Shared types and address constants for the PSX memory-mapped IO bus.
package psx_io_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    DRAIN
  } iom_state_t;

  localparam logic [31:0] IO_BASE     = 32'h1F80_1000;
  localparam logic [31:0] TIMER0_BASE = 32'h1F80_1100;
  localparam logic [31:0] TIMER1_BASE = 32'h1F80_1110;
  localparam logic [31:0] TIMER2_BASE = 32'h1F80_1120;

  // A request is rejected without a bus cycle when its size is illegal or
  // its address is not naturally aligned for that size.
  function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/io_lane_align.sv
// Byte-lane helper: byte enables and write replication from size/offset,
// plus read-data right-shift and sign/zero extension.
module io_lane_align
  import psx_io_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  // Lane selection and data formatting per access size.
  always_comb begin
    be        = '0;
    wdata_rep = wdata;
    shifted   = rdata >> {addr_lo, 3'b000};
    rdata_ext = shifted;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        be = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/io_bus_master.sv
// Initiator for the PSX IO bus: one CPU load/store at a time, strobe held
// until ack or timeout, single-cycle response pulse.
module io_bus_master
  import psx_io_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TO_W           = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  output logic        io_wen,
  output logic        io_ren,
  output logic [3:0]  io_be,
  input  logic        io_ack,
  input  logic [31:0] io_rdata
);

  iom_state_t       state_q, state_d;
  logic [TO_W-1:0]  cnt_q;
  logic             we_q, sgn_q, err_q;
  logic [1:0]       size_q, lo_q;
  logic [31:0]      rdata_q;
  logic             bad_req, idle, timeout_hit;
  logic [1:0]       al_size, al_lo;
  logic [3:0]       al_be;
  logic [31:0]      al_wdata, al_rdata;

  assign idle        = (state_q == IDLE);
  assign bad_req     = is_bad_req(req_size, req_addr[1:0]);
  assign timeout_hit = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // One aligner serves both directions: live request fields while idle,
  // latched fields while the access is in flight.
  assign al_size = idle ? req_size       : size_q;
  assign al_lo   = idle ? req_addr[1:0]  : lo_q;

  io_lane_align u_align (
    .size      (al_size),
    .addr_lo   (al_lo),
    .sign_ext  (sgn_q),
    .wdata     (req_wdata),
    .rdata     (io_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata)
  );

  assign req_ready  = idle;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. The strobe is registered at acceptance so ISSUE is
  // already the first strobe cycle and can see a zero-wait ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (req_valid) state_d = bad_req ? RESP : ISSUE;
      ISSUE, WAIT: begin
        if (io_ack || timeout_hit) state_d = RESP;
        else                       state_d = WAIT;
      end
      RESP:        state_d = io_ack ? DRAIN : IDLE;
      DRAIN:       if (!io_ack) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Request latch, bus drive, timeout count and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      we_q     <= 1'b0;
      sgn_q    <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= '0;
      lo_q     <= '0;
      rdata_q  <= '0;
      io_addr  <= '0;
      io_wdata <= '0;
      io_be    <= '0;
      io_wen   <= 1'b0;
      io_ren   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q   <= req_we;
          sgn_q  <= req_signed;
          size_q <= req_size;
          lo_q   <= req_addr[1:0];
          cnt_q  <= '0;
          if (bad_req) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            err_q    <= 1'b0;
            io_addr  <= {req_addr[31:2], 2'b00};
            io_be    <= al_be;
            io_wdata <= al_wdata;
            io_wen   <= req_we;
            io_ren   <= ~req_we;
          end
        end
        ISSUE, WAIT: begin
          if (io_ack) begin
            io_wen  <= 1'b0;
            io_ren  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= we_q ? '0 : al_rdata;
          end else if (timeout_hit) begin
            io_wen  <= 1'b0;
            io_ren  <= 1'b0;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + TO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// Randomized self-checking bench for io_bus_master with a transaction-level
// expectation model and a per-cycle compare process.
module tb_io_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] io_addr, io_wdata, io_rdata;
  logic        io_wen, io_ren, io_ack;
  logic [3:0]  io_be;

  always #5 clk = ~clk;

  io_bus_master #(.TIMEOUT_CYCLES(64), .TO_W(7)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_wen(io_wen), .io_ren(io_ren),
    .io_be(io_be), .io_ack(io_ack), .io_rdata(io_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model helpers ----------------
  function automatic int m_nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_bad(input logic [1:0] size, input logic [1:0] lo);
    if (size == 2'd3) return 1'b1;
    return (int'(lo) % m_nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] b = '0;
    for (int k = 0; k < 4; k++)
      b[k] = (k >= int'(lo)) && (k < int'(lo) + m_nbytes(size));
    return b;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] v = '0;
    for (int k = 0; k < 4; k++)
      v[8*k +: 8] = wd[8*(k % m_nbytes(size)) +: 8];
    return v;
  endfunction

  function automatic logic [31:0] m_rd(input logic [1:0] size, input logic [1:0] lo,
                                       input logic sgn, input logic [31:0] raw);
    int n = m_nbytes(size);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = raw[8*(int'(lo) + k) +: 8];
    if (sgn && n < 4 && v[8*n-1])
      for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  // ---------------- expectations and monitors ----------------
  logic        chk_en = 1'b0;
  logic        e_ready, e_wen, e_ren, e_resp, e_err;
  logic [31:0] e_rdata, e_addr, e_wdata;
  logic [3:0]  e_be;

  int          strobe_run = 0;
  int          last_strobe_len = 0;
  logic [31:0] last_rdata = '0, last_wdata = '0, last_addr = '0;
  logic [3:0]  last_be = '0;
  logic        last_err = 1'b0;

  // Per-cycle compare against the expectation set by the driver.
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      check("req_ready",  req_ready,  e_ready);
      check("io_wen",     io_wen,     e_wen);
      check("io_ren",     io_ren,     e_ren);
      check("resp_valid", resp_valid, e_resp);
      if (e_resp) begin
        check("resp_err",   resp_err,   e_err);
        check("resp_rdata", resp_rdata, e_rdata);
      end
      if (e_wen || e_ren) begin
        check("io_addr",  io_addr,  e_addr);
        check("io_be",    io_be,    e_be);
        check("io_wdata", io_wdata, e_wdata);
      end
      check("wen_ren_exclusive", io_wen & io_ren, 0);
    end
    if (io_wen || io_ren) begin
      strobe_run++;
      last_be = io_be; last_wdata = io_wdata; last_addr = io_addr;
    end else if (strobe_run != 0) begin
      last_strobe_len = strobe_run;
      strobe_run = 0;
    end
    if (resp_valid) begin
      last_rdata = resp_rdata;
      last_err   = resp_err;
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0; io_ack = 1'b0; io_rdata = $urandom;
    e_ready = 1'b1; e_wen = 1'b0; e_ren = 1'b0; e_resp = 1'b0;
    step();
  endtask

  // delay: no-ack strobe cycles before ack; hold: cycles ack stays high (>=1)
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] wd, input logic [31:0] rd,
                        input int delay, input int hold, input logic never, input logic b2b);
    int nstr;
    logic bad;
    bad = m_bad(size, addr[1:0]);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_signed = sgn; req_wdata = wd; io_ack = 1'b0; io_rdata = $urandom;
    e_ready = 1'b1; e_wen = 1'b0; e_ren = 1'b0; e_resp = 1'b0;
    step();
    req_valid = 1'b0;
    e_ready = 1'b0;
    if (bad) begin
      e_resp = 1'b1; e_err = 1'b1; e_rdata = '0; io_ack = 1'b0; req_valid = b2b;
      step();
      e_resp = 1'b0;
      return;
    end
    e_addr = {addr[31:2], 2'b00};
    e_be = m_be(size, addr[1:0]);
    e_wdata = m_wdata(size, wd);
    e_wen = we; e_ren = ~we;
    nstr = never ? 64 : delay + 1;
    for (int i = 0; i < nstr; i++) begin
      io_ack = !never && (i == delay);
      io_rdata = io_ack ? rd : $urandom;
      step();
    end
    e_wen = 1'b0; e_ren = 1'b0;
    e_resp = 1'b1; e_err = never;
    e_rdata = (never || we) ? 32'h0 : m_rd(size, addr[1:0], sgn, rd);
    io_ack = !never && (hold >= 2); io_rdata = $urandom; req_valid = b2b;
    step();
    e_resp = 1'b0;
    if (!never && hold >= 2)
      for (int k = 0; k < hold - 1; k++) begin
        io_ack = (k < hold - 2);
        step();
      end
    io_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_signed = 1'b0; req_wdata = '0; io_ack = 1'b0; io_rdata = '0;
    #2;
    check("rst_req_ready",  req_ready,  1);
    check("rst_io_wen",     io_wen,     0);
    check("rst_io_ren",     io_ren,     0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_io_be",      io_be,      0);
    check("rst_io_addr",    io_addr,    0);
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    idle_cycle();

    // half store to timer0
    do_txn(1'b1, 32'h1F80_1100, 2'd1, 1'b0, 32'h0000_0100, 32'h0, 2, 1, 1'b0, 1'b0);
    check("t1_be",    last_be,    32'h3);
    check("t1_wdata", last_wdata, 32'h0100_0100);
    check("t1_addr",  last_addr,  32'h1F80_1100);
    check("t1_strobe_len", last_strobe_len, 3);
    check("t1_err",   last_err,   0);
    idle_cycle();

    // byte load, signed then unsigned
    do_txn(1'b0, 32'h1F80_1103, 2'd0, 1'b1, 32'h0, 32'h80AA_BBCC, 0, 1, 1'b0, 1'b0);
    check("t2_be",       last_be,    32'h8);
    check("t2_signed",   last_rdata, 32'hFFFF_FF80);
    check("t2_zero_wait_strobe_len", last_strobe_len, 1);
    do_txn(1'b0, 32'h1F80_1103, 2'd0, 1'b0, 32'h0, 32'h80AA_BBCC, 1, 1, 1'b0, 1'b0);
    check("t2_unsigned", last_rdata, 32'h0000_0080);

    // misaligned word load
    do_txn(1'b0, 32'h1F80_1102, 2'd2, 1'b0, 32'h0, 32'h0, 0, 1, 1'b0, 1'b0);
    check("t3_err",   last_err,   1);
    check("t3_rdata", last_rdata, 0);
    idle_cycle();

    // no ack: timeout
    do_txn(1'b0, 32'h1F80_1110, 2'd2, 1'b0, 32'h0, 32'h0, 0, 1, 1'b1, 1'b0);
    check("t4_strobe_len", last_strobe_len, 64);
    check("t4_err",   last_err,   1);
    check("t4_rdata", last_rdata, 0);

    // held ack with back-to-back requests
    do_txn(1'b0, 32'h1F80_1104, 2'd2, 1'b0, 32'h0, 32'h1234_5678, 0, 3, 1'b0, 1'b1);
    check("t5a_rdata", last_rdata, 32'h1234_5678);
    do_txn(1'b0, 32'h1F80_1104, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 1, 1, 1'b0, 1'b0);
    check("t5b_rdata", last_rdata, 32'hCAFE_F00D);

    // reset while a store strobe is high
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1F80_1120; req_size = 2'd2;
    req_wdata = 32'hDEAD_BEEF; io_ack = 1'b0;
    e_ready = 1'b1; e_wen = 1'b0; e_ren = 1'b0; e_resp = 1'b0;
    step();
    req_valid = 1'b0; e_ready = 1'b0; e_wen = 1'b1;
    e_addr = 32'h1F80_1120; e_be = 4'hF; e_wdata = 32'hDEAD_BEEF;
    step();
    step();
    #2;
    check("t6_wen_before_rst", io_wen, 1);
    rst = 1'b1;
    #1;
    check("t6_wen_async",   io_wen,     0);
    check("t6_ren_async",   io_ren,     0);
    check("t6_resp_async",  resp_valid, 0);
    check("t6_ready_async", req_ready,  1);
    step();
    rst = 1'b0;
    idle_cycle();
    do_txn(1'b1, 32'h1F80_1120, 2'd2, 1'b0, 32'h0000_0042, 32'h0, 1, 1, 1'b0, 1'b0);
    check("t6_after_wdata", last_wdata, 32'h0000_0042);
    check("t6_after_err",   last_err,   0);

    // randomized traffic
    for (int t = 0; t < 150; t++) begin
      logic        r_we, r_sgn, r_never, r_b2b;
      logic [1:0]  r_size;
      logic [31:0] r_addr;
      int          r_delay, r_hold;
      r_we    = $urandom_range(0, 1) == 1;
      r_sgn   = $urandom_range(0, 1) == 1;
      r_size  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_addr  = 32'h1F80_1000 | ($urandom & 32'hFF);
      r_delay = $urandom_range(0, 5);
      r_hold  = $urandom_range(1, 3);
      r_never = ($urandom_range(0, 40) == 0);
      r_b2b   = ($urandom_range(0, 3) == 0);
      do_txn(r_we, r_addr, r_size, r_sgn, $urandom, $urandom,
             r_delay, r_hold, r_never, r_b2b);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
